// File: rtl/score_keeper.sv
// Score keeper for a two-player paddle game.
// Watches the ball position once per frame, awards points on misses,
// keeps BCD scores for the hex displays and sequences serve/hold/game-over.
module score_keeper #(
   parameter int          WIN_SCORE    = 11,
   parameter int          SERVE_FRAMES = 60,
   parameter int          LEFT_LIMIT   = 0,
   parameter int          RIGHT_LIMIT  = 639,
   parameter logic [7:0]  START_KEY    = 8'h2C
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_vs,
   input  logic [9:0] BallX,
   input  logic [9:0] BallY,
   input  logic [9:0] BallS,
   input  logic [7:0] keycode,
   output logic [3:0] Score1Tens,
   output logic [3:0] Score1Ones,
   output logic [3:0] Score2Tens,
   output logic [3:0] Score2Ones,
   output logic       Hold,
   output logic       Serve,
   output logic       ServeDir,
   output logic       GameOver,
   output logic       Winner
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY       = 2'd1,
      SERVE_WAIT = 2'd2,
      GAME_OVER  = 2'd3
   } state_t;

   localparam logic [10:0] LEFT_L   = 11'(LEFT_LIMIT);
   localparam logic [10:0] RIGHT_L  = 11'(RIGHT_LIMIT);
   localparam logic [6:0]  WIN_VAL  = 7'(WIN_SCORE);
   localparam logic [7:0]  SERVE_LD = 8'(SERVE_FRAMES);

   state_t     state_q;
   logic       frame_vs_q;
   logic [7:0] cnt_q;
   logic [7:0] score1_q;
   logic [7:0] score2_q;
   logic       pend_left_q;
   logic       pend_right_q;
   logic       hold_q;
   logic       serve_q;
   logic       serve_dir_q;
   logic       game_over_q;
   logic       winner_q;

   logic        frame_tick;
   logic        key_hit;
   logic [10:0] ball_x_w;
   logic [10:0] ball_s_w;
   logic        left_miss;
   logic        right_miss;
   logic [7:0]  score1_inc;
   logic [7:0]  score2_inc;
   logic        unused_bally;

   // BCD increment that saturates at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      logic [7:0] r;
      if (s == 8'h99)
         r = s;
      else if (s[3:0] == 4'd9)
         r = {s[7:4] + 4'd1, 4'd0};
      else
         r = {s[7:4], s[3:0] + 4'd1};
      return r;
   endfunction

   // Binary value of a two-digit BCD score, for the win comparison.
   function automatic logic [6:0] bcd_val(input logic [7:0] s);
      return ({3'b000, s[7:4]} * 7'd10) + {3'b000, s[3:0]};
   endfunction

   // Vertical position never affects scoring.
   assign unused_bally = ^BallY;

   assign frame_tick = frame_vs & ~frame_vs_q;
   assign key_hit    = (keycode == START_KEY);

   // Edge tests done at 11 bits so BallX + BallS cannot wrap.
   assign ball_x_w   = {1'b0, BallX};
   assign ball_s_w   = {1'b0, BallS};
   assign left_miss  = (ball_x_w <= (LEFT_L + ball_s_w));
   assign right_miss = ((ball_x_w + ball_s_w) >= RIGHT_L);

   assign score1_inc = bcd_inc(score1_q);
   assign score2_inc = bcd_inc(score2_q);

   // Delay vertical sync by one cycle for rising-edge detection.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         frame_vs_q <= 1'b0;
      else
         frame_vs_q <= frame_vs;
   end

   // Game sequencer: serve countdown, miss detection, score update, game over.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         score1_q     <= 8'h00;
         score2_q     <= 8'h00;
         pend_left_q  <= 1'b0;
         pend_right_q <= 1'b0;
         hold_q       <= 1'b1;
         serve_q      <= 1'b0;
         serve_dir_q  <= 1'b1;
         game_over_q  <= 1'b0;
         winner_q     <= 1'b0;
      end else begin
         serve_q <= 1'b0;
         case (state_q)
            IDLE: begin
               hold_q <= 1'b1;
               if (key_hit) begin
                  cnt_q   <= SERVE_LD;
                  state_q <= SERVE_WAIT;
               end
            end

            SERVE_WAIT: begin
               if (frame_tick) begin
                  if (cnt_q == 8'd1) begin
                     cnt_q   <= 8'd0;
                     serve_q <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= PLAY;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end

            PLAY: begin
               // A miss is latched on the tick and scored on the following
               // cycle; the ball is frozen in between.
               if (pend_left_q) begin
                  pend_left_q <= 1'b0;
                  score2_q    <= score2_inc;
                  if (bcd_val(score2_inc) == WIN_VAL) begin
                     game_over_q <= 1'b1;
                     winner_q    <= 1'b1;
                     state_q     <= GAME_OVER;
                  end else begin
                     cnt_q   <= SERVE_LD;
                     state_q <= SERVE_WAIT;
                  end
               end else if (pend_right_q) begin
                  pend_right_q <= 1'b0;
                  score1_q     <= score1_inc;
                  if (bcd_val(score1_inc) == WIN_VAL) begin
                     game_over_q <= 1'b1;
                     winner_q    <= 1'b0;
                     state_q     <= GAME_OVER;
                  end else begin
                     cnt_q   <= SERVE_LD;
                     state_q <= SERVE_WAIT;
                  end
               end else if (frame_tick) begin
                  // Left miss wins a tie with a simultaneous right miss.
                  if (left_miss) begin
                     pend_left_q <= 1'b1;
                     serve_dir_q <= 1'b0;
                     hold_q      <= 1'b1;
                  end else if (right_miss) begin
                     pend_right_q <= 1'b1;
                     serve_dir_q  <= 1'b1;
                     hold_q       <= 1'b1;
                  end
               end
            end

            GAME_OVER: begin
               hold_q <= 1'b1;
               if (key_hit) begin
                  score1_q    <= 8'h00;
                  score2_q    <= 8'h00;
                  game_over_q <= 1'b0;
                  cnt_q       <= SERVE_LD;
                  state_q     <= SERVE_WAIT;
               end
            end

            default: begin
               state_q <= IDLE;
               hold_q  <= 1'b1;
            end
         endcase
      end
   end

   assign Score1Tens = score1_q[7:4];
   assign Score1Ones = score1_q[3:0];
   assign Score2Tens = score2_q[7:4];
   assign Score2Ones = score2_q[3:0];
   assign Hold       = hold_q;
   assign Serve      = serve_q;
   assign ServeDir   = serve_dir_q;
   assign GameOver   = game_over_q;
   assign Winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus randomized play,
// all checked against a point/serve model kept in plain integers.
module tb_score_keeper;

   localparam int WIN   = 11;
   localparam int SF    = 3;
   localparam int LEFT  = 0;
   localparam int RIGHT = 639;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_WAIT = 2;
   localparam int M_OVER = 3;

   logic       clk;
   logic       Reset;
   logic       frame_vs;
   logic [9:0] BallX, BallY, BallS;
   logic [7:0] keycode;
   logic [3:0] Score1Tens, Score1Ones, Score2Tens, Score2Ones;
   logic       Hold, Serve, ServeDir, GameOver, Winner;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: plain integer scores and game phase.
   int m_s1, m_s2, m_mode, m_cnt;
   bit m_dir, m_go, m_win;

   score_keeper #(
      .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .LEFT_LIMIT(LEFT),
      .RIGHT_LIMIT(RIGHT), .START_KEY(8'h2C)
   ) dut (
      .Clk(clk), .Reset(Reset), .frame_vs(frame_vs),
      .BallX(BallX), .BallY(BallY), .BallS(BallS), .keycode(keycode),
      .Score1Tens(Score1Tens), .Score1Ones(Score1Ones),
      .Score2Tens(Score2Tens), .Score2Ones(Score2Ones),
      .Hold(Hold), .Serve(Serve), .ServeDir(ServeDir),
      .GameOver(GameOver), .Winner(Winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_s1 = 0; m_s2 = 0; m_mode = M_IDLE; m_cnt = 0;
      m_dir = 1'b1; m_go = 1'b0; m_win = 1'b0;
   endfunction

   function automatic void model_start();
      if (m_mode == M_IDLE) begin
         m_mode = M_WAIT; m_cnt = SF;
      end else if (m_mode == M_OVER) begin
         m_s1 = 0; m_s2 = 0; m_go = 1'b0; m_mode = M_WAIT; m_cnt = SF;
      end
   endfunction

   // One frame of game rules; returns the number of serves expected.
   function automatic int model_frame(input int x, input int s);
      int serves = 0;
      if (m_mode == M_WAIT) begin
         if (m_cnt == 1) begin
            serves = 1; m_mode = M_PLAY;
         end else m_cnt = m_cnt - 1;
      end else if (m_mode == M_PLAY) begin
         if (x <= LEFT + s) begin
            m_dir = 1'b0;
            if (m_s2 < 99) m_s2 = m_s2 + 1;
            if (m_s2 == WIN) begin m_mode = M_OVER; m_go = 1'b1; m_win = 1'b1; end
            else begin m_mode = M_WAIT; m_cnt = SF; end
         end else if (x + s >= RIGHT) begin
            m_dir = 1'b1;
            if (m_s1 < 99) m_s1 = m_s1 + 1;
            if (m_s1 == WIN) begin m_mode = M_OVER; m_go = 1'b1; m_win = 1'b0; end
            else begin m_mode = M_WAIT; m_cnt = SF; end
         end
      end
      return serves;
   endfunction

   function automatic logic [20:0] exp_vec();
      return {4'(m_s1 / 10), 4'(m_s1 % 10), 4'(m_s2 / 10), 4'(m_s2 % 10),
              (m_mode != M_PLAY), 1'b0, m_dir, m_go, m_win};
   endfunction

   function automatic logic [20:0] obs_vec();
      return {Score1Tens, Score1Ones, Score2Tens, Score2Ones,
              Hold, Serve, ServeDir, GameOver, Winner};
   endfunction

   task automatic apply_reset();
      @(negedge clk) Reset = 1'b1;
      @(negedge clk) Reset = 1'b0;
      model_reset();
   endtask

   task automatic press_start();
      @(negedge clk) keycode = 8'h2C;
      @(negedge clk);
      @(negedge clk) keycode = 8'h00;
      model_start();
   endtask

   // Drive one vertical-sync pulse and count Serve pulses that follow it.
   task automatic do_frame(input int x, input int s, output int serves);
      BallX = 10'(x); BallS = 10'(s); BallY = 10'($urandom_range(0, 479));
      @(negedge clk) frame_vs = 1'b1;
      serves = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         frame_vs = 1'b0;
         if (Serve === 1'b1) serves++;
      end
   endtask

   task automatic serve_cycle();
      int sv, es, tot_sv, tot_es;
      tot_sv = 0; tot_es = 0;
      for (int f = 0; f < SF; f++) begin
         do_frame(320, 4, sv);
         es = model_frame(320, 4);
         tot_sv += sv; tot_es += es;
      end
      n_checks++;
      if (tot_sv !== tot_es || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL serve_cycle: serves=%0d outs=%h required serves=%0d outs=%h",
                  tot_sv, obs_vec(), tot_es, exp_vec());
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      n_checks++;
      if (obs_vec() !== 21'h00_0000 + {16'h0000, 5'b10100}) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required %h", obs_vec(), {16'h0000, 5'b10100});
      end
      Reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_start_serve();
      int sv, es;
      // Start key stays held across the whole countdown and into play.
      @(negedge clk) keycode = 8'h2C;
      @(negedge clk);
      model_start();
      for (int f = 1; f <= SF; f++) begin
         do_frame(320, 4, sv);
         es = model_frame(320, 4);
         n_checks++;
         if (sv !== es || Hold !== (f != SF)) begin
            n_fail++;
            $display("FAIL start_serve frame %0d: serves=%0d hold=%b required serves=%0d hold=%b",
                     f, sv, Hold, es, (f != SF));
         end
      end
      do_frame(320, 4, sv);
      es = model_frame(320, 4);
      keycode = 8'h00;
      n_checks++;
      if (sv !== 0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL held_key_in_play: serves=%0d outs=%h required serves=0 outs=%h",
                  sv, obs_vec(), exp_vec());
      end
   endtask

   task automatic test_left_miss();
      int sv, es;
      do_frame(4, 4, sv);
      es = model_frame(4, 4);
      n_checks++;
      if (Score2Ones !== 4'd1 || ServeDir !== 1'b0 || Hold !== 1'b1 || sv !== es) begin
         n_fail++;
         $display("FAIL left_miss: s2o=%0d dir=%b hold=%b serves=%0d required 1 0 1 %0d",
                  Score2Ones, ServeDir, Hold, sv, es);
      end
      serve_cycle();
   endtask

   task automatic test_both_miss();
      int sv, es;
      do_frame(300, 400, sv);
      es = model_frame(300, 400);
      n_checks++;
      if (obs_vec() !== exp_vec() || sv !== es) begin
         n_fail++;
         $display("FAIL both_miss: got %h required %h", obs_vec(), exp_vec());
      end
      serve_cycle();
   endtask

   task automatic test_bcd_carry();
      int sv, es;
      apply_reset();
      press_start();
      serve_cycle();
      for (int p = 0; p < 9; p++) begin
         do_frame(636, 4, sv);
         es = model_frame(636, 4);
         serve_cycle();
      end
      do_frame(636, 4, sv);
      es = model_frame(636, 4);
      n_checks++;
      if (Score1Tens !== 4'd1 || Score1Ones !== 4'd0 || ServeDir !== 1'b1 || sv !== es) begin
         n_fail++;
         $display("FAIL bcd_carry: s1=%0d%0d dir=%b required 10 dir=1",
                  Score1Tens, Score1Ones, ServeDir);
      end
      serve_cycle();
   endtask

   task automatic test_win();
      int sv, es;
      apply_reset();
      press_start();
      serve_cycle();
      for (int p = 0; p < WIN - 1; p++) begin
         do_frame(4, 4, sv);
         es = model_frame(4, 4);
         serve_cycle();
      end
      do_frame(4, 4, sv);
      es = model_frame(4, 4);
      n_checks++;
      if (GameOver !== 1'b1 || Winner !== 1'b1 || sv !== 0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL game_over: go=%b win=%b serves=%0d outs=%h required 1 1 0 %h",
                  GameOver, Winner, sv, obs_vec(), exp_vec());
      end
      do_frame(320, 4, sv);
      es = model_frame(320, 4);
      n_checks++;
      if (sv !== 0 || GameOver !== 1'b1) begin
         n_fail++;
         $display("FAIL game_over_hold: serves=%0d go=%b required 0 1", sv, GameOver);
      end
      press_start();
      n_checks++;
      if (obs_vec() !== exp_vec() || Score2Ones !== 4'd0 || Score2Tens !== 4'd0) begin
         n_fail++;
         $display("FAIL restart: got %h required %h", obs_vec(), exp_vec());
      end
      serve_cycle();
   endtask

   task automatic test_reset_mid_serve();
      int sv, es;
      apply_reset();
      press_start();
      serve_cycle();
      do_frame(4, 4, sv);
      es = model_frame(4, 4);
      for (int f = 0; f < SF - 1; f++) begin
         do_frame(320, 4, sv);
         es = model_frame(320, 4);
      end
      // Assert reset between edges; outputs must clear without a clock.
      @(posedge clk);
      #2 Reset = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL async_reset: got %h required %h", obs_vec(), exp_vec());
      end
      @(negedge clk) Reset = 1'b0;
      do_frame(320, 4, sv);
      es = model_frame(320, 4);
      n_checks++;
      if (sv !== es || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_serve: serves=%0d outs=%h required serves=%0d outs=%h",
                  sv, obs_vec(), es, exp_vec());
      end
   endtask

   task automatic test_random_play();
      int sv, es, x, s, r;
      apply_reset();
      press_start();
      for (int n = 0; n < 300; n++) begin
         if (m_mode == M_OVER || m_mode == M_IDLE || $urandom_range(0, 9) == 0)
            press_start();
         s = $urandom_range(1, 30);
         r = $urandom_range(0, 3);
         if (r == 0)      x = $urandom_range(0, 40);
         else if (r == 1) x = $urandom_range(600, 660);
         else             x = $urandom_range(100, 500);
         do_frame(x, s, sv);
         es = model_frame(x, s);
         n_checks++;
         if (sv !== es || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random frame %0d x=%0d s=%0d: serves=%0d outs=%h required serves=%0d outs=%h",
                     n, x, s, sv, obs_vec(), es, exp_vec());
         end
      end
   endtask

   initial begin
      Reset = 1'b1; frame_vs = 1'b0; keycode = 8'h00;
      BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
      model_reset();
      test_reset();
      test_start_serve();
      test_left_miss();
      test_both_miss();
      test_bcd_carry();
      test_win();
      test_reset_mid_serve();
      test_random_play();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
